bcd_countdown_timer: RTL and testbench

//   Loadable multi-digit BCD down-counter (countdown timer), the decrementing

---
 rtl/bcd_pkg.sv | 29 ++
 rtl/bcd_digit_down.sv | 22 ++
 rtl/bcd_countdown_timer.sv | 96 +++++++++
 tb/tb_bcd_countdown_timer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD countdown timer: FSM states, digit limits
// and the helper used to size the prescaler.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Ceiling log2; written as a bounded loop so it folds to a constant.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Prescaler never collapses to zero bits, even when every cycle ticks.
  function automatic int psc_width(input int prescale);
    return (clog2(prescale) < 1) ? 1 : clog2(prescale);
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One decade cell of the BCD down-counter. A borrow request either steps the
// digit down or, from zero, rolls it to nine and passes the borrow upward.
module bcd_digit_down
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] next_digit,
  output logic       borrow_out
);

  // Next value of this digit given a borrow from the digit below.
  always_comb begin
    next_digit = digit;
    if (borrow_in) begin
      next_digit = (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
    end
  end

  assign borrow_out = borrow_in & (digit == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Loadable multi-digit BCD countdown timer. Counts a preset value down to
// zero, one step every PRESCALE running cycles, then pulses done for a cycle.
module bcd_countdown_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  output logic [4*DIGITS-1:0] count,
  output logic                busy,
  output logic                done
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = psc_width(PRESCALE);
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

  state_t          state;
  logic [PW-1:0]   psc;
  logic [CW-1:0]   next_count;
  logic [CW-1:0]   load_sat;
  logic [DIGITS:0] borrow;
  logic            count_zero;

  // Digit 0 always requests a decrement; the final borrow out of the chain
  // is high only when every digit is zero, which doubles as the zero flag.
  assign borrow[0]  = 1'b1;
  assign count_zero = borrow[DIGITS];

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_down u_digit (
      .digit      (count[4*k +: 4]),
      .borrow_in  (borrow[k]),
      .next_digit (next_count[4*k +: 4]),
      .borrow_out (borrow[k+1])
    );
  end

  // Clamp any non-decimal nibble of the preset to nine.
  always_comb begin
    load_sat = '0;
    for (int k = 0; k < DIGITS; k++) begin
      load_sat[4*k +: 4] = (load_val[4*k +: 4] > BCD_MAX) ? BCD_MAX : load_val[4*k +: 4];
    end
  end

  // Control FSM, prescaler and count register, in priority order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      count <= '0;
      psc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        count <= load_sat;
        psc   <= '0;
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (pause && state == ST_RUN) begin
        state <= ST_PAUSED;
      end else if (start && state == ST_IDLE) begin
        if (!count_zero) begin
          state <= ST_RUN;
          busy  <= 1'b1;
          psc   <= '0;
        end else begin
          done <= 1'b1;
        end
      end else if (start && state == ST_PAUSED) begin
        state <= ST_RUN;
      end else if (state == ST_RUN) begin
        if (psc == PSC_LAST) begin
          psc   <= '0;
          count <= next_count;
          if (next_count == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end else begin
          psc <= psc + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for the BCD countdown timer: one instance ticking every
// cycle and one with a divide-by-four prescaler, driven from shared inputs.
module tb_bcd_countdown_timer;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       pause;

  logic [7:0] count1, count4;
  logic       busy1, busy4;
  logic       done1, done4;

  int checks;
  int errors;

  logic [7:0] seq12 [12];

  bcd_countdown_timer #(.DIGITS(2), .PRESCALE(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .count    (count1),
    .busy     (busy1),
    .done     (done1)
  );

  bcd_countdown_timer #(.DIGITS(2), .PRESCALE(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .count    (count4),
    .busy     (busy4),
    .done     (done4)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one set of inputs across exactly one rising edge; returns on the
  // following falling edge so outputs are sampled away from the active edge.
  task automatic applyStimulus(input logic r, input logic l, input logic [7:0] v,
                               input logic s, input logic p);
    rst      = r;
    load     = l;
    load_val = v;
    start    = s;
    pause    = p;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    seq12 = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
              8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    rst = 1'b0; load = 1'b0; load_val = 8'h00; start = 1'b0; pause = 1'b0;
    @(negedge clk);

    // Reset after some activity
    $display("[TB] reset after activity");
    applyStimulus(1, 1, 8'h47, 0, 0);
    applyStimulus(1, 0, 8'h00, 1, 0);
    applyStimulus(1, 0, 8'h00, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkOutput("rst_count1", count1, 8'h00);
    checkOutput("rst_busy1", {7'b0, busy1}, 8'h00);
    checkOutput("rst_done1", {7'b0, done1}, 8'h00);
    checkOutput("rst_count4", count4, 8'h00);
    checkOutput("rst_busy4", {7'b0, busy4}, 8'h00);

    // Full countdown from 12 with prescale 1
    $display("[TB] countdown from 12");
    applyStimulus(1, 1, 8'h12, 0, 0);
    checkOutput("load12_count", count1, 8'h12);
    checkOutput("load12_busy", {7'b0, busy1}, 8'h00);
    applyStimulus(1, 0, 8'h00, 1, 0);
    checkOutput("start12_count", count1, 8'h12);
    checkOutput("start12_busy", {7'b0, busy1}, 8'h01);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, 8'h00, 0, 0);
      checkOutput($sformatf("seq_count_%0d", i), count1, seq12[i]);
      checkOutput($sformatf("seq_busy_%0d", i), {7'b0, busy1}, (i < 11) ? 8'h01 : 8'h00);
      checkOutput($sformatf("seq_done_%0d", i), {7'b0, done1}, (i == 11) ? 8'h01 : 8'h00);
    end
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("after_done_done", {7'b0, done1}, 8'h00);
    checkOutput("after_done_count", count1, 8'h00);

    // Saturation of non-decimal preset nibbles
    $display("[TB] load saturation");
    applyStimulus(1, 1, 8'hF3, 0, 0);
    checkOutput("sat_F3", count1, 8'h93);
    checkOutput("sat_F3_busy", {7'b0, busy1}, 8'h00);
    applyStimulus(1, 1, 8'hAB, 0, 0);
    checkOutput("sat_AB", count1, 8'h99);
    checkOutput("sat_AB_busy", {7'b0, busy1}, 8'h00);
    checkOutput("sat_AB_done", {7'b0, done1}, 8'h00);

    // Start with zero count
    $display("[TB] start at zero");
    applyStimulus(1, 1, 8'h00, 0, 0);
    checkOutput("zero_load_done", {7'b0, done1}, 8'h00);
    applyStimulus(1, 0, 8'h00, 1, 0);
    checkOutput("zero_start_done", {7'b0, done1}, 8'h01);
    checkOutput("zero_start_busy", {7'b0, busy1}, 8'h00);
    checkOutput("zero_start_count", count1, 8'h00);
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("zero_next_done", {7'b0, done1}, 8'h00);
    checkOutput("zero_next_busy", {7'b0, busy1}, 8'h00);

    // Prescale 4 with a five-edge pause
    $display("[TB] prescale 4 with pause");
    applyStimulus(1, 1, 8'h03, 0, 0);
    checkOutput("p4_load", count4, 8'h03);
    applyStimulus(1, 0, 8'h00, 1, 0);
    checkOutput("p4_start_count", count4, 8'h03);
    checkOutput("p4_start_busy", {7'b0, busy4}, 8'h01);
    repeat (3) applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("p4_e3_count", count4, 8'h03);
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("p4_e4_count", count4, 8'h02);
    applyStimulus(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 8'h00, 0, 1);
      checkOutput($sformatf("p4_pause_count_%0d", i), count4, 8'h02);
      checkOutput($sformatf("p4_pause_busy_%0d", i), {7'b0, busy4}, 8'h01);
    end
    applyStimulus(1, 0, 8'h00, 1, 0);
    checkOutput("p4_resume_count", count4, 8'h02);
    repeat (2) applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("p4_e13_count", count4, 8'h02);
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("p4_e14_count", count4, 8'h01);
    repeat (3) applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("p4_e17_count", count4, 8'h01);
    checkOutput("p4_e17_done", {7'b0, done4}, 8'h00);
    checkOutput("p4_e17_busy", {7'b0, busy4}, 8'h01);
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("p4_e18_count", count4, 8'h00);
    checkOutput("p4_e18_done", {7'b0, done4}, 8'h01);
    checkOutput("p4_e18_busy", {7'b0, busy4}, 8'h00);
    applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("p4_e19_done", {7'b0, done4}, 8'h00);

    // Load aborting a run
    $display("[TB] load mid-run");
    applyStimulus(1, 1, 8'h30, 0, 0);
    applyStimulus(1, 0, 8'h00, 1, 0);
    repeat (3) applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("abort_pre_count", count1, 8'h27);
    applyStimulus(1, 1, 8'h25, 0, 0);
    checkOutput("abort_count", count1, 8'h25);
    checkOutput("abort_busy", {7'b0, busy1}, 8'h00);
    checkOutput("abort_done", {7'b0, done1}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 8'h00, 0, 0);
      checkOutput($sformatf("abort_hold_count_%0d", i), count1, 8'h25);
      checkOutput($sformatf("abort_hold_done_%0d", i), {7'b0, done1}, 8'h00);
    end

    // Reset aborting a run
    $display("[TB] reset mid-run");
    applyStimulus(1, 1, 8'h05, 0, 0);
    applyStimulus(1, 0, 8'h00, 1, 0);
    repeat (2) applyStimulus(1, 0, 8'h00, 0, 0);
    checkOutput("rstrun_pre_count", count1, 8'h03);
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkOutput("rstrun_count", count1, 8'h00);
    checkOutput("rstrun_busy", {7'b0, busy1}, 8'h00);
    checkOutput("rstrun_done", {7'b0, done1}, 8'h00);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 8'h00, 0, 0);
      checkOutput($sformatf("rstrun_hold_done_%0d", i), {7'b0, done1}, 8'h00);
      checkOutput($sformatf("rstrun_hold_count_%0d", i), count1, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
